// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: configurable data width, parity and stop bits,
// with parity/framing/break/overrun reporting and a valid/ready output hold.
module uart_rx_frame #(
  parameter int Oversample = 16,
  parameter int DataBits   = 8,
  parameter int Parity     = 0,
  parameter int StopBits   = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                in,
  input  logic                ready,
  output logic [DataBits-1:0] data,
  output logic                valid,
  output logic                parityErr,
  output logic                frameErr,
  output logic                breakDet,
  output logic                overrun,
  output logic                busy
);

  localparam int CW = $clog2(Oversample);
  localparam int BW = $clog2(DataBits + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(Oversample - 1);
  localparam logic [CW-1:0] CNT_MID    = CW'(Oversample / 2 - 1);
  localparam logic [BW-1:0] BITS_LOAD  = BW'(DataBits);
  localparam logic          HAS_PARITY = (Parity != 0);
  localparam logic          ODD_PARITY = (Parity == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                prev_q, prev_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                par_bit_q, par_bit_d;
  logic                all_zero_q, all_zero_d;
  logic                stop_idx_q, stop_idx_d;
  logic                stop_low_q, stop_low_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                break_q, break_d;
  logic                overrun_q, overrun_d;

  logic fall, rise, mid, resync, bit_end, par_err;

  always_comb begin
    sync1_d      = in;
    sync2_d      = sync1_q;
    prev_d       = sync2_q;
    fall         = prev_q & ~sync2_q;
    rise         = ~prev_q & sync2_q;
    mid          = (cnt_q == CNT_MID);
    // An edge in the second half of a bit is taken as the next bit's boundary.
    resync       = (fall | rise) && (cnt_q < CNT_MID);
    bit_end      = (cnt_q == '0) || resync;
    par_err      = HAS_PARITY && ((^shift_q ^ par_bit_q) != ODD_PARITY);

    state_d      = state_q;
    cnt_d        = cnt_q - CW'(1);
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    all_zero_d   = all_zero_q;
    stop_idx_d   = stop_idx_q;
    stop_low_d   = stop_low_q;
    data_d       = data_q;
    valid_d      = valid_q && !ready;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    break_d      = 1'b0;
    overrun_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_LOAD;
        if (fall) begin
          state_d    = S_START;
          all_zero_d = 1'b1;
          stop_idx_d = 1'b0;
          stop_low_d = 1'b0;
          bit_cnt_d  = BITS_LOAD;
        end
      end
      S_START: begin
        if (mid && sync2_q) begin
          state_d = S_IDLE;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d   = S_DATA;
          cnt_d     = CNT_LOAD;
          bit_cnt_d = BITS_LOAD;
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {sync2_q, shift_q[DataBits-1:1]};
          if (sync2_q) all_zero_d = 1'b0;
        end
        if (bit_end) begin
          cnt_d     = CNT_LOAD;
          bit_cnt_d = bit_cnt_q - BW'(1);
          if (bit_cnt_q == BW'(1)) state_d = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid) begin
          par_bit_d = sync2_q;
          if (sync2_q) all_zero_d = 1'b0;
        end
        if (bit_end) begin
          cnt_d   = CNT_LOAD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (StopBits == 2 && !stop_idx_q) begin
            if (!sync2_q) stop_low_d = 1'b1;
            else          all_zero_d = 1'b0;
          end else begin
            // Decide at the last stop mid-sample so the next start can follow at once.
            cnt_d   = CNT_LOAD;
            state_d = S_IDLE;
            if (!sync2_q && all_zero_q) begin
              break_d = 1'b1;
              state_d = S_BREAK;
            end else if (!sync2_q || stop_low_q) begin
              frame_err_d = 1'b1;
            end else if (valid_q && !ready) begin
              overrun_d = 1'b1;
            end else begin
              data_d       = shift_q;
              valid_d      = 1'b1;
              parity_err_d = par_err;
            end
          end
        end else if (cnt_q == '0) begin
          stop_idx_d = 1'b1;
          cnt_d      = CNT_LOAD;
        end
      end
      S_BREAK: begin
        cnt_d = CNT_LOAD;
        if (rise) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= CNT_LOAD;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      all_zero_q   <= 1'b0;
      stop_idx_q   <= 1'b0;
      stop_low_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      all_zero_q   <= all_zero_d;
      stop_idx_q   <= stop_idx_d;
      stop_low_q   <= stop_low_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign parityErr = parity_err_q;
  assign frameErr  = frame_err_q;
  assign breakDet  = break_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver and the next generation of the team's fixed 8N1 receiver. It supports a configurable data width, optional even/odd parity, one or two stop bits and any oversample ratio. It reports parity, framing, break and overrun conditions, and holds received data behind a valid/ready handshake. It sits between the pad-side serial input and the bus-side RX FIFO or register interface.

## Interface
- Oversample, 16, clocks per bit; even and ≥4.
- DataBits, 8, data bits per frame; 5..9.
- Parity, 0, 0 = none, 1 = even, 2 = odd.
- StopBits, 1, 1 or 2.
- clk  in  1  single clock; all state is on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- in  in  1  raw serial line, idle high, asynchronous to clk.
- ready  in  1  consumer accepts data when high with valid.
- data  out  DataBits  last received word, LSB = first bit on the line.
- valid  out  1  data held and unconsumed.
- parityErr  out  1  one-cycle pulse, same cycle valid rises, on a parity mismatch.
- frameErr  out  1  one-cycle pulse on a stop bit sampled low (non-break).
- breakDet  out  1  one-cycle pulse on a break detection.
- overrun  out  1  one-cycle pulse when a frame completes while valid is still high.
- busy  out  1  high in any state other than IDLE.

## Operation
- Input path: 2-flop synchronizer, then a registered previous value. `fall` and `rise` are derived from these flops.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE → START on `fall`.
  - START: line high at mid-sample is a false start → IDLE with no flag. Otherwise go to DATA at the end of the bit.
  - DATA: DataBits bits → PARITY if Parity≠0, else STOP.
  - PARITY: 1 bit → STOP.
  - STOP: StopBits bits. See the completion rules below.
  - BREAK: wait for `rise` → IDLE.
- Bit timer: a down-counter of width clog2(Oversample).
  - Loads Oversample-1 on each state or bit entry.
  - Mid-sample when the counter equals Oversample/2-1.
  - Bit ends when the counter is 0.
- Resync: in DATA or PARITY, an edge while the counter is below Oversample/2-1 reloads the counter to Oversample-1, treating the edge as a bit boundary.
- Shift register fills LSB-first. The bit counter counts DataBits down to 0.
- Parity check: the XOR of the data bits and the parity bit must be 0 for even parity and 1 for odd parity.
- Completion is evaluated at the mid-sample of the final stop bit:
  - Break: all data bits, the parity bit if present, and the stop bit are 0. Pulse breakDet, do not deliver data, go to BREAK.
  - Frame error: any sampled stop bit is 0. Pulse frameErr, do not deliver data, go to IDLE.
  - Normal completion with valid low: load data, set valid, pulse parityErr if it applies, go to IDLE. The early return lets back-to-back frames start on the next `fall`.
  - Normal completion with valid high: keep the old data, pulse overrun, discard the new word, and suppress parityErr.
- Handshake: valid clears on the cycle after valid && ready. If the consumer accepts and a new word arrives in the same cycle, the new word loads, valid stays high, and there is no overrun.
- Reset mid-frame: everything returns to reset values immediately. Any partial frame is discarded.

## Timing
- Reset values: data = 0, valid = 0, all error pulses = 0, busy = 0, state = IDLE, counter = Oversample-1.
- `fall` is asserted 3 cycles after the line edge at the pin.
- Frame length from `fall`: L = (1 + DataBits + (Parity≠0) + StopBits) × Oversample clocks.
- valid rises L − Oversample/2 + 1 cycles after `fall`. For 8N1 at 16×: 153 cycles.
- Error pulses last exactly 1 cycle. busy drops in the same cycle valid rises.
- Tolerance: at least ±3% baud mismatch must be tolerated at Oversample = 16.

## Test plan
- 8N1, 16×: send 0xA5 then, immediately, 0x3C; ready held high. Expect data 0xA5 then 0x3C, each with a 1-cycle valid, and no error flags.
- DataBits=7, Parity=1 (even): send 0x55 with parity 0, then 0x55 with parity 1. Expect the first clean; the second gives valid with data 0x55 and a parityErr pulse.
- 8N2: send 0x81 with the second stop bit driven low. Expect a frameErr pulse, valid stays 0, and data is unchanged.
- Hold the line low for 20 bit times. Expect one breakDet pulse, busy high until `rise`, then IDLE and no valid.
- ready = 0: send 0x11 then 0x22. Expect data 0x11 with valid held high and an overrun pulse at the end of frame 2. Raise ready: valid clears next cycle.
- A 4-cycle low glitch on `in`: false start, no flags, busy drops after the mid-sample. Assert nReset mid-frame: all outputs read 0 in the next cycle.
